// File: rtl/and_frame_acc.sv
// and_frame_acc: folds a stream of WIDTH-bit beats into one AND/NAND
// result per frame (frame ends on in_last), presented on a valid/ready
// output with a saturating beat count.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   in_data/in_valid/in_last/mode, in_ready   input beat handshake
//   out_data/out_count/out_sat/out_valid, out_ready   result handshake
//   in_abort        (only with ANDACC_ABORT_EN) drop the partial frame
//
// Build option: define ANDACC_ABORT_EN to add the in_abort port.

module sAND (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module sNOT (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module and_frame_acc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             mode,
`ifdef ANDACC_ABORT_EN
    input  logic             in_abort,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             sat, sat_nxt;
    logic             mode_r, mode_r_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic [CNT_W-1:0] out_count_nxt;
    logic             out_sat_nxt;
    logic             out_valid_nxt;

    logic             abort;
    logic             accept;
    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] final_acc;
    logic [WIDTH-1:0] final_inv;
    logic             final_mode;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_at_max;

`ifdef ANDACC_ABORT_EN
    assign abort = in_abort && (state != HOLD);
`else
    assign abort = 1'b0;
`endif

    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;

    // acc & in_data and the inverted result, built bit by bit from
    // the primitive gates.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sAND u_and (
            .a (acc[i]),
            .b (in_data[i]),
            .y (and_vec[i])
        );
        sNOT u_not (
            .a (final_acc[i]),
            .y (final_inv[i])
        );
    end

    // On the first beat the accumulator is ignored (acc is all ones there
    // anyway after reset/drain), and mode comes straight from the port
    // because mode_r is only loaded on that same edge.
    assign final_acc  = (state == IDLE) ? in_data : and_vec;
    assign final_mode = (state == IDLE) ? mode : mode_r;

    assign cnt_at_max = (count == CNT_MAX);
    assign cnt_inc    = cnt_at_max ? count : count + 1'b1;

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        count_nxt     = count;
        sat_nxt       = sat;
        mode_r_nxt    = mode_r;
        out_data_nxt  = out_data;
        out_count_nxt = out_count;
        out_sat_nxt   = out_sat;
        out_valid_nxt = out_valid;

        unique case (state)
            IDLE: begin
                if (abort) begin
                    acc_nxt   = ONES;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                end else if (accept) begin
                    acc_nxt    = in_data;
                    count_nxt  = {{(CNT_W-1){1'b0}}, 1'b1};
                    sat_nxt    = 1'b0;
                    mode_r_nxt = mode;
                    if (in_last) begin
                        state_nxt     = HOLD;
                        out_data_nxt  = final_mode ? final_inv
                                                   : final_acc;
                        out_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                        out_sat_nxt   = 1'b0;
                        out_valid_nxt = 1'b1;
                    end else begin
                        state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (abort) begin
                    acc_nxt   = ONES;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (accept) begin
                    acc_nxt   = and_vec;
                    count_nxt = cnt_inc;
                    sat_nxt   = sat | cnt_at_max;
                    if (in_last) begin
                        state_nxt     = HOLD;
                        out_data_nxt  = final_mode ? final_inv
                                                   : final_acc;
                        out_count_nxt = cnt_inc;
                        out_sat_nxt   = sat | cnt_at_max;
                        out_valid_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    acc_nxt       = ONES;
                    count_nxt     = '0;
                    sat_nxt       = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= ONES;
            count     <= '0;
            sat       <= 1'b0;
            mode_r    <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            sat       <= sat_nxt;
            mode_r    <= mode_r_nxt;
            out_data  <= out_data_nxt;
            out_count <= out_count_nxt;
            out_sat   <= out_sat_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule
